i2c_controller: RTL and testbench

//  Single-master I2C controller (bus master) bridging a parallel request port to an open-drain SCL/SDA bus.

---
 rtl/i2c_controller.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_controller.sv
// Single-master I2C controller. Each request runs one complete bus transaction:
// START, address, R/W, DATA_WIDTH/8 data bytes, STOP. SCL and SDA are open-drain.
package i2c_controller_pkg;
  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK, WDATA, RDATA, MACK, STOP
  } state_t;
endpackage

module i2c_controller
  import i2c_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int SCL_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire                   scl,
  inout  wire                   sda,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  p_rw,
  input  logic                  i_valid,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int DIV_W   = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam int BIT_MAX = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;
  localparam int BIT_W   = $clog2(BIT_MAX);
  localparam int BYTE_W  = $clog2(NBYTES + 1);

  state_t                pres_state;
  state_t                w_next_state;

  logic [DIV_W-1:0]      r_div;        // clk count within the current quarter
  logic [1:0]            r_quarter;    // Q0..Q3 of the current bit
  logic [BIT_W-1:0]      r_bit;        // bit index within address or data byte
  logic [BYTE_W-1:0]     r_byte;       // data bytes completed so far
  logic [ADDR_WIDTH:0]   r_addr_sr;    // {address, R/W}, shifted out MSB first
  logic [DATA_WIDTH-1:0] r_wdata_sr;   // write payload, shifted out MSB first
  logic [DATA_WIDTH-1:0] r_rdata_sr;   // read payload, shifted in MSB first
  logic                  r_rw;
  logic                  r_data_phase; // address has been ACKed
  logic                  r_nack;       // target refused; finish with STOP only
  logic                  r_sda_smp;    // SDA captured at the end of Q2

  logic                  w_scl_oe;
  logic                  w_sda_oe;
  logic                  w_scl_low;
  logic                  w_sda_in;
  logic                  w_stretch;
  logic                  w_q_end;
  logic                  w_sample;
  logic                  w_bit_end;

  // Open-drain pads: only ever pull low or let the bus pull-up win.
  assign scl = w_scl_oe ? 1'b0 : 1'bz;
  assign sda = w_sda_oe ? 1'b0 : 1'bz;

  assign w_scl_low = (scl == 1'b0);
  assign w_sda_in  = (sda != 1'b0);

  // While SCL is released (Q2/Q3 of a bit) a target may hold it low; the
  // quarter timer waits until the line actually goes high.
  assign w_stretch = (pres_state != IDLE) && (pres_state != START) &&
                     r_quarter[1] && w_scl_low;
  assign w_q_end   = (r_div == DIV_W'(SCL_DIV - 1)) && !w_stretch;
  assign w_sample  = w_q_end && (r_quarter == 2'd2);
  assign w_bit_end = w_q_end && (r_quarter == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) pres_state <= IDLE;
    else        pres_state <= w_next_state;
  end

  // Next-state decode and line drive for the current state and quarter.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_next_state = pres_state;
    w_scl_oe     = 1'b0;
    w_sda_oe     = 1'b0;
    unique case (pres_state)
      IDLE: begin
        if (i_valid) w_next_state = START;
      end
      START: begin
        w_sda_oe = 1'b1;
        w_scl_oe = r_quarter[1];
        if (w_bit_end) w_next_state = ADDR;
      end
      ADDR: begin
        w_scl_oe = !r_quarter[1];
        w_sda_oe = !r_addr_sr[ADDR_WIDTH];
        if (w_bit_end && (r_bit == BIT_W'(ADDR_WIDTH))) w_next_state = ACK;
      end
      ACK: begin
        w_scl_oe = !r_quarter[1];
        if (w_bit_end) begin
          if (r_sda_smp)                         w_next_state = STOP;
          else if (!r_data_phase)                w_next_state = r_rw ? RDATA : WDATA;
          else if (r_byte == BYTE_W'(NBYTES))    w_next_state = STOP;
          else                                   w_next_state = WDATA;
        end
      end
      WDATA: begin
        w_scl_oe = !r_quarter[1];
        w_sda_oe = !r_wdata_sr[DATA_WIDTH-1];
        if (w_bit_end && (r_bit == BIT_W'(7))) w_next_state = ACK;
      end
      RDATA: begin
        w_scl_oe = !r_quarter[1];
        if (w_bit_end && (r_bit == BIT_W'(7))) w_next_state = MACK;
      end
      MACK: begin
        w_scl_oe = !r_quarter[1];
        w_sda_oe = (r_byte != BYTE_W'(NBYTES));
        if (w_bit_end) w_next_state = (r_byte == BYTE_W'(NBYTES)) ? STOP : RDATA;
      end
      STOP: begin
        w_scl_oe = !r_quarter[1];
        w_sda_oe = (r_quarter != 2'd3);
        if (w_bit_end) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Bit timing, shift registers, request capture and completion reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_quarter    <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_addr_sr    <= '0;
      r_wdata_sr   <= '0;
      r_rdata_sr   <= '0;
      r_rw         <= 1'b0;
      r_data_phase <= 1'b0;
      r_nack       <= 1'b0;
      r_sda_smp    <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
    end else begin
      o_valid <= 1'b0;
      if (pres_state == IDLE) begin
        r_div        <= '0;
        r_quarter    <= '0;
        r_bit        <= '0;
        r_byte       <= '0;
        r_data_phase <= 1'b0;
        r_nack       <= 1'b0;
        if (i_valid) begin
          r_addr_sr  <= {p_addr, p_rw};
          r_wdata_sr <= p_data;
          r_rw       <= p_rw;
        end
      end else begin
        if (!w_stretch) begin
          if (r_div == DIV_W'(SCL_DIV - 1)) begin
            r_div     <= '0;
            r_quarter <= r_quarter + 2'd1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        if (w_sample) begin
          r_sda_smp <= w_sda_in;
          if (pres_state == RDATA) r_rdata_sr <= {r_rdata_sr[DATA_WIDTH-2:0], w_sda_in};
        end

        if (w_bit_end) begin
          unique case (pres_state)
            ADDR: begin
              r_addr_sr <= r_addr_sr << 1;
              r_bit     <= (r_bit == BIT_W'(ADDR_WIDTH)) ? '0 : r_bit + BIT_W'(1);
            end
            WDATA, RDATA: begin
              if (pres_state == WDATA) r_wdata_sr <= r_wdata_sr << 1;
              if (r_bit == BIT_W'(7)) begin
                r_bit  <= '0;
                r_byte <= r_byte + BYTE_W'(1);
              end else begin
                r_bit <= r_bit + BIT_W'(1);
              end
            end
            ACK: begin
              if (r_sda_smp) r_nack       <= 1'b1;
              else           r_data_phase <= 1'b1;
            end
            STOP: begin
              if (!r_nack) begin
                o_valid <= 1'b1;
                if (r_rw) o_data <= r_rdata_sr;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a bit-level I2C target model on the bus.
module tb_i2c_controller;
  import i2c_controller_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire           scl;
  wire           sda;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  logic          p_rw = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_data;

  // Bus pull-ups and target-side open-drain drivers.
  logic tgt_scl_low = 1'b0;
  logic tgt_sda_low = 1'b0;
  pullup pu_scl (scl);
  pullup pu_sda (sda);
  assign scl = tgt_scl_low ? 1'b0 : 1'bz;
  assign sda = tgt_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCL_DIV(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .p_addr  (p_addr),
    .p_data  (p_data),
    .p_rw    (p_rw),
    .i_valid (i_valid),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target model state: bit slots counted by SCL rising edges since START.
  logic       cap [0:63];
  int         k = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         n_valid = 0;
  logic       tgt_ack_en = 1'b1;
  logic [7:0] tgt_rd [0:NB-1];
  int         stretch_slot = -1;
  int         stretch_cnt = 0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  // Whether the target pulls SDA low during bit slot s.
  function automatic logic slot_drive(input int s);
    int j;
    int b;
    if (s == 8) return tgt_ack_en;
    if (s < 9) return 1'b0;
    j = (s - 9) % 9;
    b = (s - 9) / 9;
    if (b >= NB) return 1'b0;
    if (cap[7] === 1'b1) return (j < 8) && (tgt_rd[b][7-j] == 1'b0);
    return (j == 8) && tgt_ack_en;
  endfunction

  // Bus sampler and target responder, evaluated mid-cycle when lines are settled.
  always @(negedge clk) begin
    logic cs;
    logic cd;
    cs = scl;
    cd = sda;
    if (o_valid === 1'b1) n_valid++;
    if (prev_scl === 1'b1 && cs === 1'b1 && prev_sda === 1'b1 && cd === 1'b0) begin
      n_start++;
      k = 0;
      tgt_sda_low = 1'b0;
      for (int i = 0; i < 64; i++) cap[i] = 1'bx;
    end
    if (prev_scl === 1'b1 && cs === 1'b1 && prev_sda === 1'b0 && cd === 1'b1) begin
      n_stop++;
      tgt_sda_low = 1'b0;
    end
    if (prev_scl === 1'b0 && cs === 1'b1) begin
      if (k < 64) cap[k] = cd;
      k++;
    end
    if (prev_scl === 1'b1 && cs === 1'b0) begin
      tgt_sda_low = slot_drive(k);
      if (k == stretch_slot) begin
        tgt_scl_low  = 1'b1;
        stretch_cnt  = 21;
        stretch_slot = -1;
      end
    end else if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) tgt_scl_low = 1'b0;
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  function automatic logic [7:0] cap_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = cap[base+i];
    return r;
  endfunction

  function automatic logic [AW-1:0] cap_addr();
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[AW-1-i] = cap[i];
    return r;
  endfunction

  // Cycles from the latch edge (c0) until o_valid; returns limit on timeout.
  task automatic wait_valid(input int c0, input int limit, output int lat);
    lat = limit;
    while (cyc - c0 < limit) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  // Present a one-cycle request; returns the cycle stamp of the latch edge.
  task automatic request(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw,
                         output int c0);
    @(negedge clk);
    p_addr  = a;
    p_data  = d;
    p_rw    = rw;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    c0      = cyc;
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lat;
    int s0;
    int t0;
    int v0;

    tgt_rd[0] = 8'hDE;
    tgt_rd[1] = 8'hAD;
    tgt_rd[2] = 8'hBE;
    tgt_rd[3] = 8'hEF;

    // 1. Reset with lines pulled up.
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl",   64'(scl),            64'd1);
    check("reset_sda",   64'(sda),            64'd1);
    check("reset_valid", 64'(o_valid),        64'd0);
    check("reset_data",  64'(o_data),         64'd0);
    check("reset_state", 64'(dut.pres_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 2. Write 0x12345678 to 0x50, every slot ACKed.
    s0 = n_start; t0 = n_stop; v0 = n_valid;
    request(7'h50, 32'h1234_5678, 1'b0, c0);
    wait_valid(c0, 400, lat);
    check("wr_latency", 64'(lat), 64'd188);
    @(posedge clk);
    #1;
    check("wr_valid_1cyc", 64'(o_valid),        64'd0);
    check("wr_state_idle", 64'(dut.pres_state), 64'(IDLE));
    check("wr_odata_kept", 64'(o_data),         64'd0);
    check("wr_addr",  64'(cap_addr()),  64'h50);
    check("wr_rwbit", 64'(cap[7]),      64'd0);
    check("wr_aack",  64'(cap[8]),      64'd0);
    check("wr_byte0", 64'(cap_byte(9)),  64'h12);
    check("wr_byte1", 64'(cap_byte(18)), 64'h34);
    check("wr_byte2", 64'(cap_byte(27)), 64'h56);
    check("wr_byte3", 64'(cap_byte(36)), 64'h78);
    check("wr_starts", 64'(n_start - s0), 64'd1);
    check("wr_stops",  64'(n_stop - t0),  64'd1);
    check("wr_pulses", 64'(n_valid - v0), 64'd1);

    // 3. i_valid held three cycles with changing payloads: only the first is sent.
    s0 = n_start; v0 = n_valid;
    @(negedge clk);
    p_addr = 7'h50; p_data = 32'h1234_5678; p_rw = 1'b0; i_valid = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    p_addr = 7'h00; p_data = 32'h8765_4321;
    @(posedge clk);
    #1;
    p_addr = 7'h00; p_data = 32'h0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_valid(c0, 400, lat);
    check("hold_latency", 64'(lat), 64'd188);
    repeat (20) @(posedge clk);
    #1;
    check("hold_addr",   64'(cap_addr()),  64'h50);
    check("hold_byte0",  64'(cap_byte(9)),  64'h12);
    check("hold_byte3",  64'(cap_byte(36)), 64'h78);
    check("hold_starts", 64'(n_start - s0), 64'd1);
    check("hold_pulses", 64'(n_valid - v0), 64'd1);

    // 5. Read from 0x2A; target returns DE AD BE EF.
    v0 = n_valid; t0 = n_stop;
    request(7'h2A, 32'h0, 1'b1, c0);
    wait_valid(c0, 400, lat);
    check("rd_latency", 64'(lat),       64'd188);
    check("rd_odata",   64'(o_data),    64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("rd_addr",    64'(cap_addr()), 64'h2A);
    check("rd_rwbit",   64'(cap[7]),     64'd1);
    check("rd_aack",    64'(cap[8]),     64'd0);
    check("rd_mack0",   64'(cap[17]),    64'd0);
    check("rd_mack1",   64'(cap[26]),    64'd0);
    check("rd_mack2",   64'(cap[35]),    64'd0);
    check("rd_mnack3",  64'(cap[44]),    64'd1);
    check("rd_stops",   64'(n_stop - t0),  64'd1);
    check("rd_pulses",  64'(n_valid - v0), 64'd1);

    // 4. Write to 0x00 with no target: NACK, STOP, no completion.
    tgt_ack_en = 1'b0;
    v0 = n_valid; t0 = n_stop;
    request(7'h00, 32'h5555_5555, 1'b0, c0);
    repeat (300) @(posedge clk);
    #1;
    check("nack_aack",   64'(cap[8]),           64'd1);
    check("nack_stops",  64'(n_stop - t0),      64'd1);
    check("nack_pulses", 64'(n_valid - v0),     64'd0);
    check("nack_state",  64'(dut.pres_state),   64'(IDLE));
    check("nack_odata",  64'(o_data),           64'hDEAD_BEEF);
    tgt_ack_en = 1'b1;

    // 6a. Target stretches SCL through Q2 of address bit 3.
    v0 = n_valid;
    stretch_slot = 3;
    request(7'h50, 32'hC3A5_5A3C, 1'b0, c0);
    wait_valid(c0, 400, lat);
    check("str_latency", 64'(lat), 64'd207);
    @(posedge clk);
    #1;
    check("str_addr",   64'(cap_addr()),   64'h50);
    check("str_byte0",  64'(cap_byte(9)),  64'hC3);
    check("str_byte1",  64'(cap_byte(18)), 64'hA5);
    check("str_byte2",  64'(cap_byte(27)), 64'h5A);
    check("str_byte3",  64'(cap_byte(36)), 64'h3C);
    check("str_pulses", 64'(n_valid - v0), 64'd1);
    check("str_odata",  64'(o_data),       64'hDEAD_BEEF);

    // 6b. Reset during the first WDATA bit releases both lines on that edge.
    v0 = n_valid;
    request(7'h50, 32'h1234_5678, 1'b0, c0);
    while ((dut.pres_state != WDATA) && (cyc - c0 < 100)) begin
      @(posedge clk);
      #1;
    end
    check("mid_in_wdata", 64'(dut.pres_state), 64'(WDATA));
    check("mid_scl_drv",  64'(scl),            64'd0);
    check("mid_sda_drv",  64'(sda),            64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_scl",   64'(scl),            64'd1);
    check("rst_sda",   64'(sda),            64'd1);
    check("rst_state", 64'(dut.pres_state), 64'(IDLE));
    check("rst_valid", 64'(o_valid),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    check("rst_pulses", 64'(n_valid - v0),     64'd0);
    check("rst_idle",   64'(dut.pres_state),   64'(IDLE));
    check("rst_odata",  64'(o_data),           64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
